// File: rtl/gmii_phy_frame_gen_if.sv
// gmii_phy_frame_gen_if
//   Byte stream carrying frame payload (DA through payload, no preamble or
//   FCS) into the GMII/MII PHY-side frame generator.
//   tdata  [7:0]  payload byte
//   tvalid        byte valid
//   tready        byte accepted this cycle (driven by the generator)
//   tlast         last payload byte of the frame
//   tuser         qualified by tlast: frame is bad, flag rx_er during FCS
interface gmii_phy_frame_gen_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       tlast;
    logic       tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/gmii_phy_frame_gen.sv
// gmii_phy_frame_gen
//   Turns a payload byte stream into a PHY-side GMII (1000M) or MII nibble
//   (100M/10M) receive stream toward a MAC: preamble + SFD, payload,
//   CRC-32 FCS, then an inter-frame gap. All logic runs on clk; the line
//   rate is set by the gmii_clk_en beat strobe.
//   clk          single clock (125 MHz nominal)
//   rst          synchronous, active-high reset
//   s_axis       payload byte stream (slave side)
//   speed        00=10M, 01=100M, 10/11=1000M; latched only while IDLE
//   gmii_rxd     receive data (MII: nibble on [3:0], [7:4] = 0)
//   gmii_rx_dv   receive data valid
//   gmii_rx_er   receive error
//   gmii_clk_en  one-clk strobe per byte (GMII) or nibble (MII) beat
//   busy         high whenever the generator is not IDLE
module gmii_phy_frame_gen #(
    parameter int unsigned IFG_BYTES    = 12,
    parameter int unsigned MII_DIV_100M = 5,
    parameter int unsigned MII_DIV_10M  = 50
) (
    input  logic                 clk,
    input  logic                 rst,
    gmii_phy_frame_gen_if.slave  s_axis,
    input  logic [1:0]           speed,
    output logic [7:0]           gmii_rxd,
    output logic                 gmii_rx_dv,
    output logic                 gmii_rx_er,
    output logic                 gmii_clk_en,
    output logic                 busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_DATA,
        ST_FCS,
        ST_IFG
    } state_t;

    typedef enum logic [1:0] {
        SPD_10M   = 2'b00,
        SPD_100M  = 2'b01,
        SPD_1000M = 2'b10
    } spd_t;

    // Counter covers 2*255 MII nibble beats of IFG without wrapping.
    localparam int unsigned CNT_W = 10;
    localparam int unsigned PS_W  = 16;

    localparam logic [CNT_W-1:0] PRE_LAST_G = CNT_W'(7);
    localparam logic [CNT_W-1:0] PRE_LAST_M = CNT_W'(15);
    localparam logic [CNT_W-1:0] FCS_LAST_G = CNT_W'(3);
    localparam logic [CNT_W-1:0] FCS_LAST_M = CNT_W'(7);
    localparam logic [CNT_W-1:0] IFG_LAST_G = CNT_W'(IFG_BYTES - 1);
    localparam logic [CNT_W-1:0] IFG_LAST_M = CNT_W'(2 * IFG_BYTES - 1);
    localparam logic [PS_W-1:0]  DIV100_LAST = PS_W'(MII_DIV_100M - 1);
    localparam logic [PS_W-1:0]  DIV10_LAST  = PS_W'(MII_DIV_10M - 1);

    // Reflected CRC-32 (poly 0x04C11DB7 -> 0xEDB88320), one byte per call.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int unsigned i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        end
        return r;
    endfunction

    state_t            state_q, state_d;
    spd_t              spd_q;
    spd_t              speed_norm;
    logic [PS_W-1:0]   presc_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        rxd_q, rxd_d;
    logic              dv_q, dv_d;
    logic              er_q, er_d;
    logic [31:0]       crc_q, crc_d;
    logic [3:0]        hold_q, hold_d;
    logic              nib_hi_q, nib_hi_d;
    logic              last_q, last_d;
    logic              bad_q, bad_d;
    logic              discard_q, discard_d;
    logic              tready_c;

    logic              is_gmii;
    logic              spd_chg;
    logic              presc_hit;
    logic              beat;
    logic [31:0]       fcs_val;
    logic [1:0]        fcs_idx;
    logic [7:0]        fcs_byte;
    logic [7:0]        fcs_sym;
    logic [CNT_W-1:0]  pre_last;
    logic [CNT_W-1:0]  fcs_last;
    logic [CNT_W-1:0]  ifg_last;

    always_comb begin
        speed_norm = (speed == 2'b11) ? SPD_1000M : spd_t'(speed);
        is_gmii    = (spd_q == SPD_1000M);
        spd_chg    = (state_q == ST_IDLE) && (speed_norm != spd_q);
        presc_hit  = is_gmii || (presc_q == ((spd_q == SPD_10M) ? DIV10_LAST : DIV100_LAST));
        // A beat on the same clk as a speed relatch is dropped so the new
        // rate starts cleanly from a cleared prescaler.
        beat       = !rst && presc_hit && !spd_chg;
        pre_last   = is_gmii ? PRE_LAST_G : PRE_LAST_M;
        fcs_last   = is_gmii ? FCS_LAST_G : FCS_LAST_M;
        ifg_last   = is_gmii ? IFG_LAST_G : IFG_LAST_M;
        fcs_val    = ~crc_q;
        fcs_idx    = is_gmii ? cnt_q[1:0] : cnt_q[2:1];
        fcs_byte   = 8'(fcs_val >> {fcs_idx, 3'b000});
        fcs_sym    = is_gmii ? fcs_byte
                   : (cnt_q[0] ? {4'h0, fcs_byte[7:4]} : {4'h0, fcs_byte[3:0]});
    end

    // Every output register value is chosen on a beat and becomes visible
    // in the following clk. The IDLE beat that sees tvalid already drives the
    // first preamble symbol, so IFG beats alone set the dv=0 gap.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rxd_d     = rxd_q;
        dv_d      = dv_q;
        er_d      = er_q;
        crc_d     = crc_q;
        hold_d    = hold_q;
        nib_hi_d  = nib_hi_q;
        last_d    = last_q;
        bad_d     = bad_q;
        discard_d = discard_q;
        tready_c  = 1'b0;

        // Draining the rest of an underflowed frame, independent of beats.
        if (discard_q) begin
            tready_c = 1'b1;
            if (s_axis.tvalid && s_axis.tlast) begin
                discard_d = 1'b0;
            end
        end

        if (beat) begin
            case (state_q)
                ST_IDLE: begin
                    rxd_d = '0;
                    dv_d  = 1'b0;
                    er_d  = 1'b0;
                    if (s_axis.tvalid && !discard_q) begin
                        state_d  = ST_PREAMBLE;
                        cnt_d    = CNT_W'(1);
                        crc_d    = '1;
                        nib_hi_d = 1'b0;
                        last_d   = 1'b0;
                        bad_d    = 1'b0;
                        rxd_d    = is_gmii ? 8'h55 : 8'h05;
                        dv_d     = 1'b1;
                    end
                end
                ST_PREAMBLE: begin
                    dv_d = 1'b1;
                    er_d = 1'b0;
                    if (cnt_q == pre_last) begin
                        rxd_d   = is_gmii ? 8'hD5 : 8'h0D;
                        state_d = ST_DATA;
                        cnt_d   = '0;
                    end else begin
                        rxd_d = is_gmii ? 8'h55 : 8'h05;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (is_gmii || !nib_hi_q) begin
                        tready_c = 1'b1;
                        if (s_axis.tvalid) begin
                            crc_d = crc_byte(crc_q, s_axis.tdata);
                            dv_d  = 1'b1;
                            er_d  = 1'b0;
                            bad_d = s_axis.tlast && s_axis.tuser;
                            if (is_gmii) begin
                                rxd_d = s_axis.tdata;
                                if (s_axis.tlast) begin
                                    state_d = ST_FCS;
                                    cnt_d   = '0;
                                end
                            end else begin
                                rxd_d    = {4'h0, s_axis.tdata[3:0]};
                                hold_d   = s_axis.tdata[7:4];
                                nib_hi_d = 1'b1;
                                last_d   = s_axis.tlast;
                            end
                        end else begin
                            // Underflow: one error beat, then gap, drop the rest.
                            rxd_d     = '0;
                            dv_d      = 1'b1;
                            er_d      = 1'b1;
                            state_d   = ST_IFG;
                            cnt_d     = '0;
                            discard_d = 1'b1;
                        end
                    end else begin
                        rxd_d    = {4'h0, hold_q};
                        dv_d     = 1'b1;
                        er_d     = 1'b0;
                        nib_hi_d = 1'b0;
                        if (last_q) begin
                            state_d = ST_FCS;
                            cnt_d   = '0;
                        end
                    end
                end
                ST_FCS: begin
                    rxd_d = fcs_sym;
                    dv_d  = 1'b1;
                    er_d  = bad_q;
                    if (cnt_q == fcs_last) begin
                        state_d = ST_IFG;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_IFG: begin
                    rxd_d = '0;
                    dv_d  = 1'b0;
                    er_d  = 1'b0;
                    if (cnt_q >= ifg_last) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    rxd_d   = '0;
                    dv_d    = 1'b0;
                    er_d    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            spd_q     <= SPD_1000M;
            presc_q   <= '0;
            cnt_q     <= '0;
            rxd_q     <= '0;
            dv_q      <= 1'b0;
            er_q      <= 1'b0;
            crc_q     <= '1;
            hold_q    <= '0;
            nib_hi_q  <= 1'b0;
            last_q    <= 1'b0;
            bad_q     <= 1'b0;
            discard_q <= 1'b0;
        end else begin
            if (state_q == ST_IDLE) begin
                spd_q <= speed_norm;
            end
            if (spd_chg || is_gmii || presc_hit) begin
                presc_q <= '0;
            end else begin
                presc_q <= presc_q + PS_W'(1);
            end
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rxd_q     <= rxd_d;
            dv_q      <= dv_d;
            er_q      <= er_d;
            crc_q     <= crc_d;
            hold_q    <= hold_d;
            nib_hi_q  <= nib_hi_d;
            last_q    <= last_d;
            bad_q     <= bad_d;
            discard_q <= discard_d;
        end
    end

    assign s_axis.tready = !rst && tready_c;
    assign gmii_rxd      = rxd_q;
    assign gmii_rx_dv    = dv_q;
    assign gmii_rx_er    = er_q;
    assign gmii_clk_en   = beat;
    assign busy          = !rst && (state_q != ST_IDLE);

endmodule

// File: tb/tb_gmii_phy_frame_gen.sv
// Self-checking bench for gmii_phy_frame_gen: a table of frame scenarios
// (speed, bad flag, underflow point -> expected beat statistics and tail
// symbols) plus hand-written sequences for exact symbol streams, back-to-back
// gap, beat period and reset mid-frame.
module tb_gmii_phy_frame_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] speed;
    logic [7:0] gmii_rxd;
    logic       gmii_rx_dv;
    logic       gmii_rx_er;
    logic       gmii_clk_en;
    logic       busy;

    gmii_phy_frame_gen_if axis();

    gmii_phy_frame_gen #(
        .IFG_BYTES   (12),
        .MII_DIV_100M(5),
        .MII_DIV_10M (50)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_axis     (axis),
        .speed      (speed),
        .gmii_rxd   (gmii_rxd),
        .gmii_rx_dv (gmii_rx_dv),
        .gmii_rx_er (gmii_rx_er),
        .gmii_clk_en(gmii_clk_en),
        .busy       (busy)
    );

    always #4 clk = ~clk;

    typedef struct packed {
        logic [7:0] rxd;
        logic       dv;
        logic       er;
    } beat_t;

    typedef struct {
        logic [1:0]      spd;
        bit              bad;
        int              drop_at;
        int              exp_dv;
        int              exp_er;
        int              exp_first_er;
        logic [3:0][7:0] tail;      // tail[3] is 4th-from-last dv symbol
        int              exp_drained;
    } vec_t;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [7:0]  pay   [9];
    logic [7:0]  exp_g [21];
    logic [7:0]  exp_m [42];
    beat_t       cap[$];
    bit          cap_en = 1'b0;
    bit          en_seen = 1'b0;

    int          n_dv, n_er, first_er, runs, gap, gap_acc;
    logic [7:0]  dvs[$];

    // Outputs change in the clk after a beat; record them there.
    always @(negedge clk) begin
        if (cap_en && en_seen) cap.push_back({gmii_rxd, gmii_rx_dv, gmii_rx_er});
        en_seen = gmii_clk_en;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic scan();
        bit prev;
        n_dv = 0; n_er = 0; first_er = -1; runs = 0; gap = -1; gap_acc = 0; prev = 1'b0;
        dvs.delete();
        foreach (cap[i]) begin
            if (cap[i].er) n_er++;
            if (cap[i].dv) begin
                if (!prev) begin
                    runs++;
                    if (runs == 2) gap = gap_acc;
                end
                if (cap[i].er && first_er < 0) first_er = n_dv;
                dvs.push_back(cap[i].rxd);
                n_dv++;
            end else if (runs == 1) begin
                gap_acc++;
            end
            prev = cap[i].dv;
        end
    endtask

    task automatic send_frame(input int n, input bit bad, input int drop_at, output int drained);
        int t;
        drained = 0;
        for (int i = 0; i < n; i++) begin
            if (i == drop_at) begin
                axis.tvalid = 1'b0;
                repeat (150) @(posedge clk);
                #1;
            end
            axis.tvalid = 1'b1;
            axis.tdata  = pay[i];
            axis.tlast  = (i == n - 1);
            axis.tuser  = bad && (i == n - 1);
            t = 0;
            @(negedge clk);
            while (!axis.tready && t < 3000) begin
                @(negedge clk);
                t++;
            end
            chk("handshake_timeout", int'(t >= 3000), 0);
            if (drop_at >= 0 && i >= drop_at && t == 0) drained++;
            @(posedge clk);
            #1;
        end
        axis.tvalid = 1'b0;
        axis.tlast  = 1'b0;
        axis.tuser  = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge clk);
        while (busy && t < 10000) begin
            @(negedge clk);
            t++;
        end
        chk("idle_timeout", int'(t >= 10000), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_stream_m(input string name, input int base);
        int mism;
        mism = 0;
        for (int i = 0; i < 42; i++) if (dvs[base + i] !== exp_m[i]) mism++;
        chk(name, mism, 0);
    endtask

    task automatic chk_stream_g(input string name, input int base);
        int mism;
        mism = 0;
        for (int i = 0; i < 21; i++) if (dvs[base + i] !== exp_g[i]) mism++;
        chk(name, mism, 0);
    endtask

    vec_t        vecs[7];
    logic [31:0] fcs_nib;

    initial begin
        int dr, t, p;

        for (int i = 0; i < 9; i++) pay[i] = 8'h31 + 8'(i);
        for (int i = 0; i < 7; i++) exp_g[i] = 8'h55;
        exp_g[7] = 8'hD5;
        for (int i = 0; i < 9; i++) exp_g[8 + i] = pay[i];
        exp_g[17] = 8'h26; exp_g[18] = 8'h39; exp_g[19] = 8'hF4; exp_g[20] = 8'hCB;
        for (int i = 0; i < 15; i++) exp_m[i] = 8'h05;
        exp_m[15] = 8'h0D;
        for (int i = 0; i < 9; i++) begin
            exp_m[16 + 2 * i] = {4'h0, pay[i][3:0]};
            exp_m[17 + 2 * i] = {4'h0, pay[i][7:4]};
        end
        fcs_nib = 32'h6293_4FBC;
        for (int k = 0; k < 8; k++) exp_m[34 + k] = {4'h0, fcs_nib[31 - 4 * k -: 4]};

        vecs[0] = '{2'b10, 1'b0, -1, 21, 0, -1, {8'h26, 8'h39, 8'hF4, 8'hCB}, 0};
        vecs[1] = '{2'b11, 1'b0, -1, 21, 0, -1, {8'h26, 8'h39, 8'hF4, 8'hCB}, 0};
        vecs[2] = '{2'b10, 1'b1, -1, 21, 4, 17, {8'h26, 8'h39, 8'hF4, 8'hCB}, 0};
        vecs[3] = '{2'b01, 1'b0, -1, 42, 0, -1, {8'h04, 8'h0F, 8'h0B, 8'h0C}, 0};
        vecs[4] = '{2'b01, 1'b1, -1, 42, 8, 34, {8'h04, 8'h0F, 8'h0B, 8'h0C}, 0};
        vecs[5] = '{2'b10, 1'b0,  3, 12, 1, 11, {8'h31, 8'h32, 8'h33, 8'h00}, 6};
        vecs[6] = '{2'b01, 1'b0,  3, 23, 1, 22, {8'h03, 8'h03, 8'h03, 8'h00}, 6};

        rst = 1'b1;
        speed = 2'b10;
        axis.tvalid = 1'b0;
        axis.tdata  = '0;
        axis.tlast  = 1'b0;
        axis.tuser  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rxd", int'(gmii_rxd), 0);
        chk("rst_dv", int'(gmii_rx_dv), 0);
        chk("rst_er", int'(gmii_rx_er), 0);
        chk("rst_tready", int'(axis.tready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_clk_en", int'(gmii_clk_en), 0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        for (int v = 0; v < 7; v++) begin
            speed = vecs[v].spd;
            repeat (4) @(posedge clk);
            #1;
            cap.delete();
            cap_en = 1'b1;
            send_frame(9, vecs[v].bad, vecs[v].drop_at, dr);
            wait_idle();
            cap_en = 1'b0;
            scan();
            chk($sformatf("v%0d_dv_beats", v), n_dv, vecs[v].exp_dv);
            chk($sformatf("v%0d_dv_runs", v), runs, 1);
            chk($sformatf("v%0d_er_beats", v), n_er, vecs[v].exp_er);
            chk($sformatf("v%0d_first_er", v), first_er, vecs[v].exp_first_er);
            chk($sformatf("v%0d_first_sym", v), int'(dvs[0]), (vecs[v].spd == 2'b01) ? 5 : 'h55);
            for (int k = 0; k < 4; k++)
                chk($sformatf("v%0d_tail%0d", v, k), int'(dvs[n_dv - 4 + k]), int'(vecs[v].tail[3 - k]));
            chk($sformatf("v%0d_drained", v), dr, vecs[v].exp_drained);
            if (v == 0) chk_stream_g("gmii_stream", 0);
            if (v == 3) chk_stream_m("mii100_stream", 0);
        end

        // Beat period at 100M while idle.
        t = 0;
        @(negedge clk);
        while (!gmii_clk_en && t < 100) begin @(negedge clk); t++; end
        chk("clk_en_seen", int'(gmii_clk_en), 1);
        for (int r = 0; r < 2; r++) begin
            p = 0;
            do begin @(negedge clk); p++; end while (!gmii_clk_en && p < 100);
            chk("clk_en_period", p, 5);
        end

        // Back-to-back frames at 1000M.
        speed = 2'b10;
        repeat (4) @(posedge clk);
        #1;
        cap.delete();
        cap_en = 1'b1;
        send_frame(9, 1'b0, -1, dr);
        send_frame(9, 1'b0, -1, dr);
        wait_idle();
        cap_en = 1'b0;
        scan();
        chk("b2b_runs", runs, 2);
        chk("b2b_gap", gap, 12);
        chk("b2b_dv_beats", n_dv, 42);
        chk_stream_g("b2b_frame1", 0);
        chk_stream_g("b2b_frame2", 21);

        // Reset pulsed during DATA at 10M.
        speed = 2'b00;
        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            axis.tvalid = 1'b1;
            axis.tdata  = pay[i];
            t = 0;
            @(negedge clk);
            while (!axis.tready && t < 3000) begin @(negedge clk); t++; end
            chk("rst_seq_handshake_timeout", int'(t >= 3000), 0);
            @(posedge clk);
            #1;
        end
        axis.tvalid = 1'b0;
        @(negedge clk);
        chk("pre_rst_dv", int'(gmii_rx_dv), 1);
        rst = 1'b1;
        #1;
        chk("in_rst_clk_en", int'(gmii_clk_en), 0);
        chk("in_rst_tready", int'(axis.tready), 0);
        chk("in_rst_busy", int'(busy), 0);
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_dv", int'(gmii_rx_dv), 0);
        chk("post_rst_rxd", int'(gmii_rxd), 0);
        rst = 1'b0;
        cap.delete();
        cap_en = 1'b1;
        send_frame(9, 1'b0, -1, dr);
        wait_idle();
        cap_en = 1'b0;
        scan();
        chk("after_rst_dv_beats", n_dv, 42);
        chk("after_rst_runs", runs, 1);
        chk("after_rst_er", n_er, 0);
        chk_stream_m("after_rst_stream", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
